// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl: read-side controller for an HD44780-style 16x2 character LCD.
// Runs one of two operations per request:
//   op=0  single busy-flag / address-counter read
//   op=1  DDRAM byte read: set-address write, busy-flag polling, then data read
// Each bus access is SETUP (T_AS) -> E high (T_PW) -> E low (T_EL) cycles.
//
// Ports:
//   clock_50, reset       clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op, req_addr      operation select and 7-bit DDRAM address
//   done, timeout_err     completion pulse and poll-timeout flag (valid with done)
//   rd_data               raw byte from the last read access
//   busy_flag, addr_counter  fields of the last BF/AC read
//   lcd_rs, lcd_rw, lcd_e LCD control pins
//   data_out, data_oe     split data bus drive side (top level builds the inout)
//   data_in               data bus pin values
module lcd_read_ctrl #(
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_PW      = 12,
  parameter int unsigned T_EL      = 12,
  parameter int unsigned MAX_POLLS = 8
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [6:0] req_addr,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_counter,
  output logic       timeout_err,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  localparam int unsigned ACC_LEN = T_AS + T_PW + T_EL;
  localparam int unsigned CW      = $clog2(ACC_LEN);
  localparam int unsigned PW      = $clog2(MAX_POLLS + 1);

  // Offsets inside one access: first E-high cycle, capture cycle (E falls), last cycle.
  localparam logic [CW-1:0] CNT_EHI  = CW'(T_AS);
  localparam logic [CW-1:0] CNT_CAP  = CW'(T_AS + T_PW - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_POLL = 3'd2;
  localparam logic [2:0] S_BF   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]    rd_q, rd_d;
  logic          bf_q, bf_d;
  logic [6:0]    ac_q, ac_d;
  logic          to_q, to_d;
  logic [7:0]    dout_q, dout_d;

  logic in_acc, acc_end, cap;

  assign in_acc  = (state_q == S_ADDR) || (state_q == S_POLL) ||
                   (state_q == S_BF)   || (state_q == S_DATA);
  assign acc_end = in_acc && (cnt_q == CNT_LAST);
  // The address access is a write, so nothing is captured during it.
  assign cap     = in_acc && (state_q != S_ADDR) && (cnt_q == CNT_CAP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    rd_d    = rd_q;
    bf_d    = bf_q;
    ac_d    = ac_q;
    to_d    = to_q;
    dout_d  = dout_q;

    if (in_acc) begin
      cnt_d = acc_end ? '0 : cnt_q + 1'b1;
    end

    if (cap) begin
      rd_d = data_in;
      if (state_q != S_DATA) begin
        bf_d = data_in[7];
        ac_d = data_in[6:0];
      end
      if (state_q == S_POLL) begin
        poll_d = poll_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          to_d  = 1'b0;
          cnt_d = '0;
          if (req_op) begin
            state_d = S_ADDR;
            dout_d  = {1'b1, req_addr};
          end else begin
            state_d = S_BF;
          end
        end
      end
      S_ADDR: begin
        if (acc_end) begin
          state_d = S_POLL;
          poll_d  = '0;
        end
      end
      S_POLL: begin
        // bf_q and poll_q already hold this poll's result by the last access cycle.
        if (acc_end) begin
          if (!bf_q) begin
            state_d = S_DATA;
          end else if (poll_q == POLL_MAX) begin
            state_d = S_DONE;
            to_d    = 1'b1;
          end
        end
      end
      S_BF, S_DATA: begin
        if (acc_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      poll_q  <= '0;
      rd_q    <= '0;
      bf_q    <= 1'b0;
      ac_q    <= '0;
      to_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      rd_q    <= rd_d;
      bf_q    <= bf_d;
      ac_q    <= ac_d;
      to_q    <= to_d;
      dout_q  <= dout_d;
    end
  end

  // Bus controls decode straight from reset-cleared state, so reset drops them at once.
  assign req_ready    = (state_q == S_IDLE);
  assign done         = (state_q == S_DONE);
  assign timeout_err  = (state_q == S_DONE) && to_q;
  assign lcd_e        = in_acc && (cnt_q >= CNT_EHI) && (cnt_q <= CNT_CAP);
  assign lcd_rs       = (state_q == S_DATA);
  assign lcd_rw       = in_acc && (state_q != S_ADDR);
  assign data_oe      = (state_q == S_ADDR);
  assign data_out     = dout_q;
  assign rd_data      = rd_q;
  assign busy_flag    = bf_q;
  assign addr_counter = ac_q;

endmodule

// File: doc/lcd_read_ctrl.md
Name: lcd_read_ctrl

Overview:
- HD44780-style LCD read-side controller for the 16x2 character LCD path; the companion to the existing write/display driver.
- Accepts a read request and runs the LCD bus read cycle (RW=1) with E timing generated from clock_50.
- Two operations: a single busy-flag/address-counter read, and a DDRAM byte read. The byte read is a set-address write, then busy-flag polling, then a data read.
- Drives split data signals (data_out, data_oe, data_in); the top level ties these to the inout data_bus pins.

Parameters:
- T_AS, 2: cycles RS/RW/data are stable before E rises (address setup).
- T_PW, 12: cycles E is held high. Must be ≥ 1.
- T_EL, 12: cycles E is held low after falling (hold/cycle recovery). Must be ≥ 1.
- MAX_POLLS, 8: maximum busy-flag polls before a timeout error is reported.

Ports:
- clock_50, in, 1: system clock, 50 MHz.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request strobe, sampled only while req_ready=1.
- req_ready, out, 1: high in IDLE only.
- req_op, in, 1: 0 = read BF/AC; 1 = read DDRAM byte at req_addr.
- req_addr, in, 7: DDRAM address, used when req_op=1.
- done, out, 1: one-cycle pulse when an operation finishes (success or timeout).
- rd_data, out, 8: raw byte read by the last access. Held until the next done.
- busy_flag, out, 1: bit 7 of the last BF/AC read.
- addr_counter, out, 7: bits 6:0 of the last BF/AC read.
- timeout_err, out, 1: valid with done. 1 = MAX_POLLS reached with BF still set.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read/write (1 = read).
- lcd_e, out, 1: LCD enable strobe.
- data_out, out, 8: write data for the address command.
- data_oe, out, 1: 1 = FPGA drives data_bus.
- data_in, in, 8: data_bus pin values.

Behaviour:
- Reset values:
  - req_ready=1.
  - done, timeout_err, lcd_rs, lcd_rw, lcd_e, data_oe = 0.
  - data_out, rd_data, addr_counter = 0; busy_flag=0.
  - Reset asserted mid-operation aborts immediately: lcd_e and data_oe drop asynchronously and the FSM returns to IDLE. No done pulse is issued.
- Access primitive (ACC): SETUP for T_AS cycles, then EHI for T_PW cycles, then ELO for T_EL cycles, giving A = T_AS+T_PW+T_EL cycles (26 at defaults).
  - lcd_rs and lcd_rw are set on entry to SETUP and held through ELO.
  - lcd_e=1 only in EHI.
  - For reads, data_in is registered on the last EHI cycle (the edge on which E falls).
  - For the write access, data_oe=1 and data_out is stable from SETUP through ELO. data_oe=0 in every read access and in IDLE.
- FSM states and transitions:
  - IDLE: on req_valid&req_ready, latch op and addr.
    - op=0 → BF_ACC.
    - op=1 → ADDR_ACC with rs=0, rw=0, data_out={1,addr}.
  - ADDR_ACC: write access, then → POLL_ACC with poll count = 0.
  - POLL_ACC: read access with rs=0, rw=1. Update busy_flag/addr_counter/rd_data and increment the poll count.
    - If BF=0 → DATA_ACC.
    - Else if count==MAX_POLLS → DONE with timeout_err=1.
    - Else → POLL_ACC.
  - BF_ACC: read access with rs=0, rw=1. Update rd_data/busy_flag/addr_counter, then → DONE. No polling.
  - DATA_ACC: read access with rs=1, rw=1. Update rd_data only, then → DONE.
  - DONE: done=1 for one cycle, then → IDLE. timeout_err is valid only while done=1 and is 0 otherwise.
- Latency: the accept edge is cycle 0 and SETUP begins on cycle 1.
  - done asserts at cycle 1 + n·A, where n = number of accesses in the operation.
  - req_ready deasserts at cycle 1.
- Request handling:
  - req_valid while req_ready=0 is ignored, not queued.
  - A req_valid in the done cycle is ignored. A new request is accepted in IDLE at the earliest.
- req_addr bit widths: only 7 bits are used. Address command = 0x80 | req_addr.

Test Plan:
- op=0, bus model drives 0x85 during EHI → done at cycle 27; rd_data=0x85, busy_flag=1, addr_counter=0x05, timeout_err=0. lcd_e high exactly cycles 3–14, lcd_rw=1, data_oe=0 throughout.
- op=1, addr=0x40; BF reads 0x80 for 3 polls, then 0x00; data read returns 0x41 → data_out=0xC0 with data_oe=1 and rs=0 during the first access. Data access uses rs=1, rw=1. done at cycle 1+6·26=157 with rd_data=0x41, timeout_err=0.
- op=1, BF stuck at 0x80 → exactly 8 polls, then done at cycle 1+9·26=235 with timeout_err=1. No data access (rs never 1).
- Reset pulsed low during EHI of the first poll → lcd_e=0 and data_oe=0 immediately; req_ready=1 after release; no done pulse. The next op=0 request completes normally.
- req_valid held high continuously with op=0 → back-to-back operations. Each done is followed by IDLE before the next acceptance; a second request during an active access is never latched mid-operation.
